seq_detect_arbiter: RTL

Time-shares one 11101 pattern-detection engine across NUM_CH independent serial bit streams. A round-robin arbiter accepts at most one bit per cycle through a per-channel valid/ready handshake. The engine keeps a 3-bit detector context per channel, restores it for the granted channel, advances it, and writes it back. Sits between the serial-input front ends and the event/interrupt logic; it reports each detected match tagged with its channel.

---
 rtl/seq_detect_arbiter_pkg.sv | 32 +++
 rtl/seq_detect_arbiter_if.sv | 26 ++
 rtl/seq_detect_arbiter_rr.sv | 47 ++++
 rtl/seq_detect_arbiter.sv | 95 +++++++++
 4 files changed

// File: rtl/seq_detect_arbiter_pkg.sv
// Shared types and the 11101 detector step used by the time-shared engine.
package seq_detect_pkg;

    // Moore detector states; the name records the matched prefix of 11101.
    typedef enum logic [2:0] {
        S0 = 3'd0,   // ""
        S1 = 3'd1,   // "1"
        S2 = 3'd2,   // "11"
        S3 = 3'd3,   // "111"
        S4 = 3'd4,   // "1110"
        S5 = 3'd5    // "11101" (match)
    } det_state_t;

    localparam det_state_t MATCH_STATE = S5;

    // One overlapping detector step. Encodings 6 and 7 fall back to S0.
    function automatic det_state_t next_state(input det_state_t cur, input logic din);
        det_state_t nxt;
        nxt = S0;
        case (cur)
            S0:      nxt = din ? S1 : S0;
            S1:      nxt = din ? S2 : S0;
            S2:      nxt = din ? S3 : S0;
            S3:      nxt = din ? S3 : S4;
            S4:      nxt = din ? S5 : S0;
            S5:      nxt = din ? S2 : S0;
            default: nxt = S0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/seq_detect_arbiter_if.sv
// Per-channel bit handshake plus match reporting bundle.
interface seq_detect_arbiter_if #(
    parameter int NUM_CH  = 4,
    parameter int COUNT_W = 16,
    parameter int CH_W    = $clog2(NUM_CH)
);
    logic [NUM_CH-1:0]  bit_valid;
    logic [NUM_CH-1:0]  bit_data;
    logic [NUM_CH-1:0]  bit_ready;
    logic [NUM_CH-1:0]  ch_clear;
    logic               match_valid;
    logic [CH_W-1:0]    match_ch;
    logic [COUNT_W-1:0] match_count;

    // Front ends and event logic side.
    modport master (
        output bit_valid, bit_data, ch_clear,
        input  bit_ready, match_valid, match_ch, match_count
    );

    // Detection engine side.
    modport slave (
        input  bit_valid, bit_data, ch_clear,
        output bit_ready, match_valid, match_ch, match_count
    );
endinterface

// File: rtl/seq_detect_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after the pointer,
// cyclic, plus the pointer value to load when that grant is accepted.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   ptr_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [CH_W-1:0]   gnt_idx_o,
    output logic              gnt_any_o,
    output logic [CH_W-1:0]   ptr_next_o
);

    // Scan from the pointer, wrapping once; first hit wins.
    always_comb begin
        int idx;
        logic [CH_W-1:0] idx_w;
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_any_o = 1'b0;
        idx       = 0;
        idx_w     = '0;
        for (int off = 0; off < NUM_CH; off++) begin
            idx = int'(ptr_i) + off;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            idx_w = CH_W'(idx);
            if (!gnt_any_o && req_i[idx_w]) begin
                gnt_any_o    = 1'b1;
                gnt_o[idx_w] = 1'b1;
                gnt_idx_o    = idx_w;
            end
        end
    end

    // Pointer moves just past the winner, wrapping at NUM_CH-1.
    always_comb begin
        if (gnt_idx_o == CH_W'(NUM_CH - 1)) begin
            ptr_next_o = '0;
        end else begin
            ptr_next_o = gnt_idx_o + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detect_arbiter.sv
// Time-shared 11101 detector: one bit per cycle from a round-robin-selected
// channel advances that channel's stored context; matches are reported one
// cycle later with the channel index and counted (saturating).
module seq_detect_arbiter
    import seq_detect_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CH_W    = $clog2(NUM_CH),
    parameter int COUNT_W = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    seq_detect_arbiter_if.slave bus
);

    logic [NUM_CH-1:0]  req;
    logic [NUM_CH-1:0]  gnt;
    logic [CH_W-1:0]    gnt_idx;
    logic               gnt_any;
    logic [CH_W-1:0]    ptr_next;

    logic [CH_W-1:0]    rr_ptr_q, rr_ptr_d;
    det_state_t         ctx_q [NUM_CH];
    det_state_t         ctx_d [NUM_CH];
    logic               match_valid_q, match_valid_d;
    logic [CH_W-1:0]    match_ch_q, match_ch_d;
    logic [COUNT_W-1:0] match_count_q, match_count_d;

    // A clearing channel is withheld from arbitration so its bit is retried.
    assign req = bus.bit_valid & ~bus.ch_clear & {NUM_CH{enable & ~reset}};

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_rr_arbiter (
        .req_i      (req),
        .ptr_i      (rr_ptr_q),
        .gnt_o      (gnt),
        .gnt_idx_o  (gnt_idx),
        .gnt_any_o  (gnt_any),
        .ptr_next_o (ptr_next)
    );

    assign bus.bit_ready = gnt;

    // Context update: clear wins, otherwise only the granted channel steps.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ctx_d[i] = ctx_q[i];
            if (bus.ch_clear[i]) begin
                ctx_d[i] = S0;
            end else if (gnt[i]) begin
                ctx_d[i] = next_state(ctx_q[i], bus.bit_data[i]);
            end
        end
    end

    // Pointer, match pulse, channel tag and saturating count next-state.
    always_comb begin
        rr_ptr_d      = gnt_any ? ptr_next : rr_ptr_q;
        match_valid_d = gnt_any && (ctx_d[gnt_idx] == MATCH_STATE);
        match_ch_d    = match_valid_d ? gnt_idx : match_ch_q;
        match_count_d = match_count_q;
        if (match_valid_d && (match_count_q != {COUNT_W{1'b1}})) begin
            match_count_d = match_count_q + 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ctx_q[i] <= S0;
            end
            rr_ptr_q      <= '0;
            match_valid_q <= 1'b0;
            match_ch_q    <= '0;
            match_count_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                ctx_q[i] <= ctx_d[i];
            end
            rr_ptr_q      <= rr_ptr_d;
            match_valid_q <= match_valid_d;
            match_ch_q    <= match_ch_d;
            match_count_q <= match_count_d;
        end
    end

    assign bus.match_valid = match_valid_q;
    assign bus.match_ch    = match_ch_q;
    assign bus.match_count = match_count_q;

endmodule
